conv_systolic_engine: RTL and testbench

- Parametrised successor to the fixed 2x2 systolic convolution block.
- Computes one OUT_N x OUT_N tile of a valid-mode 2-D convolution: an IN_N x IN_N unsigned image with a K x K unsigned kernel, where IN_N = OUT_N+K-1.
- Operands arrive on a single valid/ready load stream and results leave on a valid/ready output stream, so the block sits between a feature-map buffer and a result writer.
- Output-stationary PE grid: one MAC per PE per cycle.

---
 rtl/conv_systolic_engine.sv | 188 ++++++++++++++++++
 tb/tb_conv_systolic_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_systolic_engine.sv
// Output-stationary systolic engine computing one OUT_N x OUT_N tile of a valid-mode 2-D convolution.
// Define CONV_BIAS_EN to take a bias word after the weights and preload every accumulator with it.
module conv_systolic_engine #(
    parameter int DW    = 8,
    parameter int OUT_N = 2,
    parameter int K     = 3,
    parameter int ACC_W = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int IN_N = OUT_N + K - 1;
    localparam int KK   = K * K;
    localparam int NPIX = IN_N * IN_N;
    localparam int NOUT = OUT_N * OUT_N;
`ifdef CONV_BIAS_EN
    localparam int BIAS_WORDS = 1;
`else
    localparam int BIAS_WORDS = 0;
`endif
    localparam int PIX_OFF = KK + BIAS_WORDS;
    localparam int LD_LEN  = PIX_OFF + NPIX;
    localparam int LW      = $clog2(LD_LEN);
    localparam int KW      = (KK > 1) ? $clog2(KK) : 1;
    localparam int RW      = (K > 1) ? $clog2(K) : 1;
    localparam int PW      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int OW      = (NOUT > 1) ? $clog2(NOUT) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t state, next_state;

    logic [LW-1:0]    ld_cnt;
    logic [KW-1:0]    k_cnt;
    logic [RW-1:0]    kr, kc;
    logic [OW-1:0]    o_idx;
    logic [DW-1:0]    weight [KK];
    logic [DW-1:0]    pix    [NPIX];
    logic [ACC_W-1:0] acc    [NOUT];
    logic [2*DW-1:0]  prod   [NOUT];
    logic [ACC_W-1:0] sel_acc;
    logic [ACC_W-1:0] acc_init;
    logic             ld_fire, ld_last, mac_last, out_fire;

    assign ld_fire  = ld_valid && ld_ready;
    assign ld_last  = (ld_cnt == LW'(LD_LEN - 1));
    assign mac_last = (k_cnt == KW'(KK - 1));
    assign out_fire = out_valid && out_ready;
    assign sel_acc  = acc[o_idx];

`ifdef CONV_BIAS_EN
    logic [DW-1:0] bias;
    assign acc_init = ACC_W'(bias);
`else
    assign acc_init = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        case (state)
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) begin
                    next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (mac_last) begin
                    next_state = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (o_idx == OW'(NOUT - 1));
                // Anything that does not fit in DW bits clamps to full scale
                out_data  = (|sel_acc[ACC_W-1:DW]) ? '1 : sel_acc[DW-1:0];
                if (out_ready && out_last) begin
                    next_state = S_LOAD;
                end
            end
            default: next_state = S_LOAD;
        endcase
    end

    // Operand storage needs no reset: every tile rewrites all of it before use
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            if (ld_cnt < LW'(KK)) begin
                weight[KW'(ld_cnt)] <= ld_data;
            end else if (ld_cnt >= LW'(PIX_OFF)) begin
                pix[PW'(ld_cnt - LW'(PIX_OFF))] <= ld_data;
            end
`ifdef CONV_BIAS_EN
            else begin
                bias <= ld_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt <= '0;
            k_cnt  <= '0;
            kr     <= '0;
            kc     <= '0;
            o_idx  <= '0;
        end else begin
            if (ld_fire) begin
                ld_cnt <= ld_last ? '0 : ld_cnt + LW'(1);
            end
            if (state == S_COMPUTE) begin
                if (mac_last) begin
                    k_cnt <= '0;
                    kr    <= '0;
                    kc    <= '0;
                end else begin
                    k_cnt <= k_cnt + KW'(1);
                    if (kc == RW'(K - 1)) begin
                        kc <= '0;
                        kr <= kr + RW'(1);
                    end else begin
                        kc <= kc + RW'(1);
                    end
                end
            end
            if (out_fire) begin
                o_idx <= out_last ? '0 : o_idx + OW'(1);
            end
        end
    end

    // All PEs share the current weight; each reads the pixel offset by its own grid position
    always_comb begin
        prod = '{default: '0};
        for (int r = 0; r < OUT_N; r++) begin
            for (int c = 0; c < OUT_N; c++) begin
                prod[r*OUT_N+c] = (2*DW)'(weight[k_cnt])
                                * (2*DW)'(pix[PW'((r + int'(kr)) * IN_N + c + int'(kc))]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NOUT; i++) begin
                acc[i] <= '0;
            end
        end else if (ld_fire && ld_last) begin
            for (int i = 0; i < NOUT; i++) begin
                acc[i] <= acc_init;
            end
        end else if (state == S_COMPUTE) begin
            for (int i = 0; i < NOUT; i++) begin
                acc[i] <= acc[i] + ACC_W'(prod[i]);
            end
        end
    end

endmodule

// File: tb/tb_conv_systolic_engine.sv
// Self-checking bench for conv_systolic_engine: a per-cycle scoreboard fed by a plain-arithmetic
// convolution model, plus literal expectations for the known tiles (CONV_BIAS_EN aware).
`timescale 1ns/1ps
module tb_conv_systolic_engine;

    localparam int DW    = 8;
    localparam int OUT_N = 2;
    localparam int K     = 3;
    localparam int ACC_W = 20;
    localparam int IN_N  = OUT_N + K - 1;
    localparam int KK    = K * K;
    localparam int NPIX  = IN_N * IN_N;
    localparam int NOUT  = OUT_N * OUT_N;
`ifdef CONV_BIAS_EN
    localparam int BIAS_WORDS = 1;
    localparam int S1_BIAS    = 10;
    localparam int S2_BIAS    = 255;
    localparam int S2_ACC     = 585480;
    int s1_exp [NOUT] = '{188, 187, 144, 175};
`else
    localparam int BIAS_WORDS = 0;
    localparam int S1_BIAS    = 0;
    localparam int S2_BIAS    = 0;
    localparam int S2_ACC     = 585225;
    int s1_exp [NOUT] = '{178, 177, 134, 165};
`endif
    localparam int PIX_OFF = KK + BIAS_WORDS;
    localparam int LEN     = PIX_OFF + NPIX;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          ld_valid  = 1'b0;
    logic [DW-1:0] ld_data   = '0;
    logic          out_ready = 1'b1;
    logic          ld_ready, busy, out_valid, out_last;
    logic [DW-1:0] out_data;

    int checks = 0;
    int errors = 0;

    int w1 [KK]   = '{1, 5, 8, 6, 0, 7, 3, 1, 2};
    int x1 [NPIX] = '{8, 3, 9, 1, 7, 7, 2, 8, 5, 6, 3, 1, 4, 9, 2, 6};
    int w_max [KK]   = '{default: 255};
    int x_max [NPIX] = '{default: 255};
    int sat_exp [NOUT] = '{default: 255};
    int stream [LEN];

    // Scoreboard state, advanced only by the compare process
    bit loading = 1'b1;
    bit exp_ov;
    bit seen_ov = 1'b0;
    int wcnt = 0, since = 0, out_cnt = 0, first_lat = -1;
    int cap [LEN];
    int exp_q [$];
    int got_q [$];
    int ready_mode = 0;

    conv_systolic_engine #(
        .DW(DW), .OUT_N(OUT_N), .K(K), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data(ld_data),
        .busy(busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input longint exp);
        checks++;
        if (act !== 64'(exp)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Direct definition of a valid-mode convolution, one output word at a time
    function automatic int model_word(input int s[LEN], input int idx);
        int r, c;
        longint a;
        r = idx / OUT_N;
        c = idx % OUT_N;
        a = 0;
        if (BIAS_WORDS == 1) a = s[KK];
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                a += longint'(s[i*K+j]) * longint'(s[PIX_OFF + (r+i)*IN_N + c + j]);
        return (a > 255) ? 255 : int'(a);
    endfunction

    task automatic build_stream(input int w[KK], input int x[NPIX], input int b);
        for (int i = 0; i < KK; i++) stream[i] = w[i];
        if (BIAS_WORDS == 1) stream[KK] = b;
        for (int i = 0; i < NPIX; i++) stream[PIX_OFF+i] = x[i];
    endtask

    task automatic apply_stimulus(input int gap_pct);
        for (int i = 0; i < LEN; i++) begin
            int guard;
            bit done;
            while ($urandom_range(99) < gap_pct) begin
                ld_valid = 1'b0;
                @(posedge clk); #1;
            end
            ld_valid = 1'b1;
            ld_data  = DW'(stream[i]);
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge clk);
                done = ld_ready;
                @(posedge clk); #1;
                guard++;
                if (!done && guard > 500) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL load_timeout: word %0d not accepted, ld_ready=%0d, required 1", i, ld_ready);
                    ld_valid = 1'b0;
                    return;
                end
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!(loading && exp_q.size() == 0 && wcnt == 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: %0d results still pending, required 0", exp_q.size());
        end
    endtask

    task automatic check_tile(input string name, input int exp[NOUT]);
        check_output({name, "_count"}, 64'(got_q.size()), NOUT);
        for (int i = 0; i < NOUT && i < got_q.size(); i++)
            check_output({name, "_word"}, 64'(got_q[i]), exp[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       out_ready = ($urandom_range(2) == 0) ? 1'b0 : 1'b1;
                2:       out_ready = 1'($urandom_range(1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Per-cycle compare against the scoreboard; handshakes are observed before the edge that completes them
    always @(negedge clk) begin
        if (!rst) begin
            loading = 1'b1;
            wcnt    = 0;
            since   = 0;
            out_cnt = 0;
            seen_ov = 1'b0;
            exp_q.delete();
        end else begin
            if (!loading) since++;
            check_output("ld_ready", 64'(ld_ready), loading);
            check_output("busy", 64'(busy), !loading);
            exp_ov = !loading && since >= KK + 1;
            check_output("out_valid", 64'(out_valid), exp_ov);
            if (out_valid && !seen_ov) begin
                seen_ov   = 1'b1;
                first_lat = since;
            end
            if (out_valid && exp_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_output: got word %0d, required none", out_data);
                end else begin
                    check_output("out_data", 64'(out_data), exp_q[0]);
                    check_output("out_last", 64'(out_last), out_cnt == NOUT - 1);
                    if (out_ready) begin
                        got_q.push_back(int'(out_data));
                        void'(exp_q.pop_front());
                        if (out_cnt == NOUT - 1) begin
                            out_cnt = 0;
                            loading = 1'b1;
                            seen_ov = 1'b0;
                        end else begin
                            out_cnt++;
                        end
                    end
                end
            end
            if (ld_valid && ld_ready && loading) begin
                cap[wcnt] = int'(ld_data);
                if (wcnt == LEN - 1) begin
                    for (int i = 0; i < NOUT; i++) exp_q.push_back(model_word(cap, i));
                    wcnt    = 0;
                    loading = 1'b0;
                    since   = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rw [KK];
        int rx [NPIX];
        int rexp [2*NOUT];
        int lim;
        int rb;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ld_ready", 64'(ld_ready), 1);
        check_output("rst_busy", 64'(busy), 0);
        check_output("rst_out_valid", 64'(out_valid), 0);
        check_output("rst_out_data", 64'(out_data), 0);
        check_output("rst_out_last", 64'(out_last), 0);

        build_stream(w1, x1, S1_BIAS);
        for (int i = 0; i < NOUT; i++) check_output("model_pin_s1", 64'(model_word(stream, i)), s1_exp[i]);
        build_stream(w_max, x_max, S2_BIAS);
        for (int i = 0; i < NOUT; i++) check_output("model_pin_sat", 64'(model_word(stream, i)), 255);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic tile");
        got_q.delete();
        build_stream(w1, x1, S1_BIAS);
        apply_stimulus(0);
        wait_idle(200);
        check_tile("s1", s1_exp);
        check_output("latency", 64'(first_lat), 10);

        $display("[TB] saturation");
        got_q.delete();
        build_stream(w_max, x_max, S2_BIAS);
        apply_stimulus(0);
        lim = 0;
        while (!out_valid && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        check_output("sat_acc0", 64'(dut.acc[0]), S2_ACC);
        check_output("sat_acc3", 64'(dut.acc[3]), S2_ACC);
        wait_idle(200);
        check_tile("sat", sat_exp);

        $display("[TB] backpressure");
        ready_mode = 1;
        got_q.delete();
        build_stream(w1, x1, S1_BIAS);
        apply_stimulus(0);
        wait_idle(400);
        check_tile("bp", s1_exp);
        ready_mode = 0;

        $display("[TB] random back-to-back tiles with load gaps");
        ready_mode = 2;
        for (int t = 0; t < 12; t++) begin
            got_q.delete();
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(2))
                    0:       lim = 15;
                    1:       lim = 40;
                    default: lim = 255;
                endcase
                for (int i = 0; i < KK; i++) rw[i] = $urandom_range(lim);
                for (int i = 0; i < NPIX; i++) rx[i] = $urandom_range(lim);
                rb = $urandom_range(255);
                build_stream(rw, rx, rb);
                for (int i = 0; i < NOUT; i++) rexp[p*NOUT+i] = model_word(stream, i);
                apply_stimulus(30);
            end
            wait_idle(600);
            check_output("b2b_count", 64'(got_q.size()), 2 * NOUT);
            for (int i = 0; i < 2*NOUT && i < got_q.size(); i++)
                check_output("b2b_word", 64'(got_q[i]), rexp[i]);
        end
        ready_mode = 0;

        $display("[TB] reset during compute");
        got_q.delete();
        build_stream(w1, x1, S1_BIAS);
        apply_stimulus(0);
        repeat (4) @(posedge clk);
        #1;
        check_output("k_before_reset", 64'(dut.k_cnt), 4);
        rst = 1'b0;
        #1;
        check_output("mid_rst_ld_ready", 64'(ld_ready), 1);
        check_output("mid_rst_busy", 64'(busy), 0);
        check_output("mid_rst_out_valid", 64'(out_valid), 0);
        check_output("mid_rst_out_data", 64'(out_data), 0);
        check_output("mid_rst_out_last", 64'(out_last), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        apply_stimulus(0);
        wait_idle(200);
        check_tile("after_rst", s1_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
